// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers deriving totals and sync windows.
package vga_timing_pkg;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned CNT_MAX      = 1 << CNT_W;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_VIS    = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_VIS    = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Total pixels (or lines) in one period of the axis.
  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  // First coordinate inside the sync pulse.
  function automatic int unsigned sync_start(input int unsigned vis, input int unsigned fp);
    return vis + fp;
  endfunction

  // First coordinate after the sync pulse.
  function automatic int unsigned sync_end(input int unsigned vis, input int unsigned fp,
                                           input int unsigned sync);
    return vis + fp + sync;
  endfunction

  localparam int unsigned H_TOT    = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned V_TOT    = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int unsigned HS_START = sync_start(DEF_H_VIS, DEF_H_FP);
  localparam int unsigned HS_END   = sync_end(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC);
  localparam int unsigned VS_START = sync_start(DEF_V_VIS, DEF_V_FP);
  localparam int unsigned VS_END   = sync_end(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_pix_en.sv
// Pixel-rate clock enable: registered one-clk pulse every CLK_DIV system clocks.
module vga_pix_en #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_pix_en: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div;

  // pix_en rises in the clk where the divider has wrapped from its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with zero-skew registered sync/bright and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_VIS       = DEF_H_VIS,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VIS       = DEF_V_VIS,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam int unsigned H_TOTL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTL - 1);

  // Window bounds one bit wider so a bound equal to 1024 is representable.
  localparam logic [CMP_W-1:0] H_VIS_B = CMP_W'(H_VIS);
  localparam logic [CMP_W-1:0] V_VIS_B = CMP_W'(V_VIS);
  localparam logic [CMP_W-1:0] HS_S    = CMP_W'(sync_start(H_VIS, H_FP));
  localparam logic [CMP_W-1:0] HS_E    = CMP_W'(sync_end(H_VIS, H_FP, H_SYNC));
  localparam logic [CMP_W-1:0] VS_S    = CMP_W'(sync_start(V_VIS, V_FP));
  localparam logic [CMP_W-1:0] VS_E    = CMP_W'(sync_end(V_VIS, V_FP, V_SYNC));

  if (H_TOTL > CNT_MAX || V_TOTL > CNT_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOT and V_TOT must not exceed 1024");
  end

  vga_pix_en #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hs_on;
  logic             vs_on;
  logic             bright_nxt;
  logic             line_nxt;
  logic             frame_nxt;

  // Next raster position plus the qualifiers it implies, so registered outputs line up.
  always_comb begin
    h_nxt = hCount;
    v_nxt = vCount;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
      end else begin
        h_nxt = hCount + CNT_W'(1);
      end
    end
    hs_on      = ({1'b0, h_nxt} >= HS_S) && ({1'b0, h_nxt} < HS_E);
    vs_on      = ({1'b0, v_nxt} >= VS_S) && ({1'b0, v_nxt} < VS_E);
    bright_nxt = ({1'b0, h_nxt} < H_VIS_B) && ({1'b0, v_nxt} < V_VIS_B);
    line_nxt   = pix_en && (hCount == H_LAST);
    frame_nxt  = line_nxt && (vCount == V_LAST);
  end

  // Reset parks the raster on the last blanking pixel; the first pix_en rolls to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount      <= H_LAST;
      vCount      <= V_LAST;
      hSync       <= ~SYNC_ACTIVE;
      vSync       <= ~SYNC_ACTIVE;
      bright      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      hSync       <= hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vSync       <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bright      <= bright_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default (div 2), default at div 1, and a tiny raster (div 3, active-high sync).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_pe, a_hs, a_vs, a_br, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_pe, b_hs, b_vs, b_br, b_ls, b_fs;
  logic [9:0] b_h, b_v;
  logic       c_pe, c_hs, c_vs, c_br, c_ls, c_fs;
  logic [9:0] c_h, c_v;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(a_pe), .hSync(a_hs), .vSync(a_vs), .bright(a_br),
    .hCount(a_h), .vCount(a_v), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(b_pe), .hSync(b_hs), .vSync(b_vs), .bright(b_br),
    .hCount(b_h), .vCount(b_v), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .pix_en(c_pe), .hSync(c_hs), .vSync(c_vs), .bright(c_br),
    .hCount(c_h), .vCount(c_v), .line_start(c_ls), .frame_start(c_fs)
  );

  int checks = 0;
  int errors = 0;

  // Clock edges since the most recent reset release.
  int k = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Expected outputs after edge kk: pixels elapsed = floor((kk-1)/d), raster resting at the last pixel.
  function automatic logic [25:0] model(input int kk, input int d,
                                        input int hv, input int hf, input int hsw, input int hb,
                                        input int vv, input int vf, input int vsw, input int vb,
                                        input bit sa);
    int ht, vt, tt, n, p, h, v;
    bit pe, adv, ls, fs, hs, vs, br;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    tt  = ht * vt;
    n   = (kk >= 1) ? (kk - 1) / d : 0;
    p   = (n + tt - 1) % tt;
    h   = p % ht;
    v   = p / ht;
    pe  = (kk >= 1) && (kk % d == 0);
    adv = (kk - 1 >= d) && ((kk - 1) % d == 0);
    ls  = adv && (h == 0);
    fs  = ls && (v == 0);
    hs  = (h >= hv + hf && h < hv + hf + hsw) ? sa : !sa;
    vs  = (v >= vv + vf && v < vv + vf + vsw) ? sa : !sa;
    br  = (h < hv) && (v < vv);
    return {pe, hs, vs, br, 10'(h), 10'(v), ls, fs};
  endfunction

  task automatic chk_vec(input string nm, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got pe,hs,vs,br,h,v,ls,fs=%b,%b,%b,%b,%0d,%0d,%b,%b expected %b,%b,%b,%b,%0d,%0d,%b,%b",
               nm, k, got[25], got[24], got[23], got[22], got[21:12], got[11:2], got[1], got[0],
               exp[25], exp[24], exp[23], exp[22], exp[21:12], exp[11:2], exp[1], exp[0]);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0d expected %0d", nm, k, got, exp);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    #1;
    chk_vec("model_a", {a_pe, a_hs, a_vs, a_br, a_h, a_v, a_ls, a_fs},
            model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    chk_vec("model_b", {b_pe, b_hs, b_vs, b_br, b_h, b_v, b_ls, b_fs},
            model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    chk_vec("model_c", {c_pe, c_hs, c_vs, c_br, c_h, c_v, c_ls, c_fs},
            model(k, 3, 8, 2, 3, 3, 6, 1, 2, 1, 1'b1));
  end

  int a_ls_n, a_hs_low, b_ls_n, c_fs_n, c_vs_act, guard;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    lit("rst_a_hcount", int'(a_h), 799);
    lit("rst_a_vcount", int'(a_v), 524);
    lit("rst_a_hsync", int'(a_hs), 1);
    lit("rst_a_vsync", int'(a_vs), 1);
    lit("rst_a_bright", int'(a_br), 0);
    lit("rst_a_pix_en", int'(a_pe), 0);
    lit("rst_c_hsync", int'(c_hs), 0);
    rst_n = 1'b1;

    a_ls_n = 0; a_hs_low = 0; b_ls_n = 0; c_fs_n = 0; c_vs_act = 0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      #2;
      if (k >= 3 && k < 1603) begin
        a_ls_n   += int'(a_ls);
        a_hs_low += int'(!a_hs);
      end
      if (k >= 2 && k < 802) b_ls_n += int'(b_ls);
      if (k >= 4 && k < 484) begin
        c_fs_n   += int'(c_fs);
        c_vs_act += int'(c_vs);
      end
      case (k)
        1:    lit("a_pix_en_k1", int'(a_pe), 0);
        2: begin
          lit("a_pix_en_k2", int'(a_pe), 1);
          lit("a_hcount_k2", int'(a_h), 799);
          lit("b_frame_start_k2", int'(b_fs), 1);
          lit("b_hcount_k2", int'(b_h), 0);
        end
        3: begin
          lit("a_hcount_k3", int'(a_h), 0);
          lit("a_vcount_k3", int'(a_v), 0);
          lit("a_bright_k3", int'(a_br), 1);
          lit("a_frame_start_k3", int'(a_fs), 1);
        end
        4: begin
          lit("a_frame_start_k4", int'(a_fs), 0);
          lit("a_hcount_k4", int'(a_h), 0);
          lit("c_frame_start_k4", int'(c_fs), 1);
        end
        658:  lit("b_hsync_h656", int'(b_hs), 0);
        1281: lit("a_bright_h639", int'(a_br), 1);
        1283: begin
          lit("a_hcount_k1283", int'(a_h), 640);
          lit("a_bright_h640", int'(a_br), 0);
        end
        1313: lit("a_hsync_h655", int'(a_hs), 1);
        1315: lit("a_hsync_h656", int'(a_hs), 0);
        1505: lit("a_hsync_h751", int'(a_hs), 0);
        1507: lit("a_hsync_h752", int'(a_hs), 1);
        1601: lit("a_vcount_h799", int'(a_v), 0);
        1603: begin
          lit("a_hcount_wrap", int'(a_h), 0);
          lit("a_vcount_wrap", int'(a_v), 1);
          lit("a_line_start_l1", int'(a_ls), 1);
        end
        802:  lit("b_line_start_l1", int'(b_ls), 1);
        483:  lit("c_vcount_last", int'(c_v), 9);
        484: begin
          lit("c_vcount_wrap", int'(c_v), 0);
          lit("c_frame_start_f1", int'(c_fs), 1);
        end
        default: ;
      endcase
    end
    lit("a_line_starts_per_line", a_ls_n, 1);
    lit("a_hsync_low_clks", a_hs_low, 192);
    lit("b_line_starts_per_line", b_ls_n, 1);
    lit("c_frame_starts_per_frame", c_fs_n, 1);
    lit("c_vsync_active_clks", c_vs_act, 96);

    // Asynchronous reset pulse in the middle of a line.
    guard = 0;
    while (a_h != 10'd300 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    lit("reach_a_h300", int'(a_h), 300);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    lit("async_a_hcount", int'(a_h), 799);
    lit("async_a_vcount", int'(a_v), 524);
    lit("async_a_hsync", int'(a_hs), 1);
    lit("async_a_bright", int'(a_br), 0);
    lit("async_a_pix_en", int'(a_pe), 0);
    lit("async_b_hcount", int'(b_h), 799);
    lit("async_c_vsync", int'(c_vs), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #2;
      if (k == 3) begin
        lit("restart_a_hcount", int'(a_h), 0);
        lit("restart_a_vcount", int'(a_v), 0);
        lit("restart_a_frame_start", int'(a_fs), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
